// File: rtl/ll_rx_frame_gen.sv
// Store-and-forward GMAC client receive local-link generator fed from an 8-bit AXI-Stream slave.
// Frames are fully buffered before emission so rx_data_valid never gaps inside a frame.
module ll_rx_frame_gen #(
   parameter int unsigned C_BUF_DEPTH     = 4096,
   parameter int unsigned C_DESC_DEPTH    = 16,
   parameter int unsigned C_MAX_FRAME_LEN = 1518,
   parameter int unsigned C_IFG           = 12
) (
   input  logic        axi_aclk,
   input  logic        axi_resetn,
   input  logic [7:0]  s_axis_tdata,
   input  logic        s_axis_tstrb,
   input  logic        s_axis_tuser,
   input  logic        s_axis_tvalid,
   output logic        s_axis_tready,
   input  logic        s_axis_tlast,
   output logic [7:0]  rx_data,
   output logic        rx_data_valid,
   output logic        rx_good_frame,
   output logic        rx_bad_frame,
   output logic [31:0] good_count,
   output logic [31:0] bad_count,
   output logic [31:0] drop_count
);

   localparam int unsigned AW  = $clog2(C_BUF_DEPTH);
   localparam int unsigned CW  = AW + 1;
   localparam int unsigned DAW = $clog2(C_DESC_DEPTH);
   localparam int unsigned DCW = DAW + 1;
   localparam int unsigned LW  = 11;
   localparam int unsigned GW  = (C_IFG > 1) ? $clog2(C_IFG) : 1;

   typedef struct packed {
      logic          bad;
      logic [LW-1:0] len;
   } desc_t;

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_STATUS, S_GAP} state_t;

   logic [7:0]     buf_mem [C_BUF_DEPTH];
   desc_t          desc_mem [C_DESC_DEPTH];

   logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]  byte_cnt_q, byte_cnt_d;
   logic [DAW-1:0] dwr_ptr_q, drd_ptr_q;
   logic [DCW-1:0] desc_cnt_q, desc_cnt_d;
   logic [LW-1:0]  wr_len_q;
   logic           trunc_q;
   logic [7:0]     rd_byte_q;

   state_t         state_q;
   logic [LW-1:0]  frame_len_q, cnt_q;
   logic           frame_bad_q;
   logic [GW-1:0]  gap_q;

   logic           beat_c, room_c, store_c, over_c, push_c, drop_c;
   logic [LW-1:0]  len_new_c;
   desc_t          push_desc_c, head_c;
   logic           pop_c, last_c, rd_en_c;

   assign s_axis_tready = (byte_cnt_q != CW'(C_BUF_DEPTH)) && (desc_cnt_q != DCW'(C_DESC_DEPTH));

   // Write-side beat decode; the tlast beat's own byte counts toward the descriptor length.
   always_comb begin
      beat_c          = s_axis_tvalid & s_axis_tready;
      room_c          = wr_len_q < LW'(C_MAX_FRAME_LEN);
      store_c         = beat_c & s_axis_tstrb & room_c;
      over_c          = beat_c & s_axis_tstrb & ~room_c;
      len_new_c       = wr_len_q + LW'(store_c);
      push_c          = beat_c & s_axis_tlast & (len_new_c != '0);
      drop_c          = beat_c & s_axis_tlast & (len_new_c == '0);
      push_desc_c.bad = s_axis_tuser | trunc_q | over_c;
      push_desc_c.len = len_new_c;
   end

   // Read-side decode: one buffer read on descriptor pop, then one per byte still owed.
   always_comb begin
      head_c  = desc_mem[drd_ptr_q];
      pop_c   = (state_q == S_IDLE) && (desc_cnt_q != '0);
      last_c  = (cnt_q + LW'(1)) == frame_len_q;
      rd_en_c = pop_c || ((state_q == S_SEND) && !last_c);
   end

   always_comb begin
      byte_cnt_d = byte_cnt_q + CW'(store_c) - CW'(rd_en_c);
      desc_cnt_d = desc_cnt_q + DCW'(push_c) - DCW'(pop_c);
   end

   always_ff @(posedge axi_aclk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         wr_ptr_q   <= '0;
         dwr_ptr_q  <= '0;
         byte_cnt_q <= '0;
         desc_cnt_q <= '0;
         wr_len_q   <= '0;
         trunc_q    <= 1'b0;
         drop_count <= '0;
      end else begin
         byte_cnt_q <= byte_cnt_d;
         desc_cnt_q <= desc_cnt_d;
         if (store_c) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (push_c)  dwr_ptr_q <= dwr_ptr_q + DAW'(1);
         if (drop_c)  drop_count <= drop_count + 32'd1;
         if (beat_c && s_axis_tlast) begin
            wr_len_q <= '0;
            trunc_q  <= 1'b0;
         end else begin
            wr_len_q <= len_new_c;
            trunc_q  <= trunc_q | over_c;
         end
      end
   end

   // Storage arrays carry no reset so they map onto block RAM with a registered read.
   always_ff @(posedge axi_aclk) begin
      if (store_c) buf_mem[wr_ptr_q] <= s_axis_tdata;
      if (rd_en_c) rd_byte_q <= buf_mem[rd_ptr_q];
      if (push_c)  desc_mem[dwr_ptr_q] <= push_desc_c;
   end

   always_ff @(posedge axi_aclk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         state_q       <= S_IDLE;
         rd_ptr_q      <= '0;
         drd_ptr_q     <= '0;
         frame_len_q   <= '0;
         frame_bad_q   <= 1'b0;
         cnt_q         <= '0;
         gap_q         <= '0;
         rx_data       <= '0;
         rx_data_valid <= 1'b0;
         rx_good_frame <= 1'b0;
         rx_bad_frame  <= 1'b0;
         good_count    <= '0;
         bad_count     <= '0;
      end else begin
         rx_data_valid <= 1'b0;
         rx_good_frame <= 1'b0;
         rx_bad_frame  <= 1'b0;
         if (rd_en_c) rd_ptr_q <= rd_ptr_q + AW'(1);
         case (state_q)
            S_IDLE: begin
               if (pop_c) begin
                  drd_ptr_q   <= drd_ptr_q + DAW'(1);
                  frame_len_q <= head_c.len;
                  frame_bad_q <= head_c.bad;
                  cnt_q       <= '0;
                  state_q     <= S_SEND;
               end
            end
            S_SEND: begin
               rx_data       <= rd_byte_q;
               rx_data_valid <= 1'b1;
               cnt_q         <= cnt_q + LW'(1);
               if (last_c) state_q <= S_STATUS;
            end
            S_STATUS: begin
               if (frame_bad_q) begin
                  rx_bad_frame <= 1'b1;
                  bad_count    <= bad_count + 32'd1;
               end else begin
                  rx_good_frame <= 1'b1;
                  good_count    <= good_count + 32'd1;
               end
               gap_q   <= '0;
               state_q <= (C_IFG == 0) ? S_IDLE : S_GAP;
            end
            S_GAP: begin
               if (gap_q == GW'(C_IFG - 1)) state_q <= S_IDLE;
               else                         gap_q   <= gap_q + GW'(1);
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ll_rx_frame_gen.sv
// Scoreboard bench for ll_rx_frame_gen: stimulus queues expected bytes/status per frame,
// an independent monitor pops and compares whatever the receive local-link presents.
module tb_ll_rx_frame_gen;

   localparam int MAXL = 1518;
   localparam int IFG  = 12;

   logic        axi_aclk = 1'b0;
   logic        axi_resetn;
   logic [7:0]  s_axis_tdata;
   logic        s_axis_tstrb, s_axis_tuser, s_axis_tvalid, s_axis_tready, s_axis_tlast;
   logic [7:0]  rx_data;
   logic        rx_data_valid, rx_good_frame, rx_bad_frame;
   logic [31:0] good_count, bad_count, drop_count;

   ll_rx_frame_gen #(
      .C_BUF_DEPTH(4096), .C_DESC_DEPTH(16), .C_MAX_FRAME_LEN(MAXL), .C_IFG(IFG)
   ) dut (
      .axi_aclk(axi_aclk), .axi_resetn(axi_resetn),
      .s_axis_tdata(s_axis_tdata), .s_axis_tstrb(s_axis_tstrb), .s_axis_tuser(s_axis_tuser),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
      .rx_data(rx_data), .rx_data_valid(rx_data_valid),
      .rx_good_frame(rx_good_frame), .rx_bad_frame(rx_bad_frame),
      .good_count(good_count), .bad_count(bad_count), .drop_count(drop_count)
   );

   always #5 axi_aclk = ~axi_aclk;

   typedef struct {
      int len;
      bit bad;
   } frame_t;

   byte unsigned exp_bytes[$];
   frame_t       exp_frames[$];
   int checks = 0, failures = 0;
   int st_good = 0, st_bad = 0, st_drop = 0;
   int mon_good = 0, mon_bad = 0, idx = 0, cur_len = 0, low_run = 0, last_gap = -1;
   bit in_frame = 0, prev_valid = 0, saw_stall = 0;
   byte unsigned m_e;
   frame_t       m_f;

   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s: actual=%0d required=%0d @%0t", name, act, req, $time);
      end
   endtask

   task automatic flag(input string name);
      checks++;
      failures++;
      $display("FAIL %s @%0t", name, $time);
   endtask

   // Monitor: consumes expected bytes and frame statuses in output order.
   initial forever begin
      @(negedge axi_aclk);
      if (!axi_resetn) begin
         exp_bytes.delete();
         exp_frames.delete();
         in_frame = 0; idx = 0; mon_good = 0; mon_bad = 0; prev_valid = 0; low_run = 0;
      end else begin
         if (rx_data_valid) begin
            if (!in_frame) begin
               if (exp_frames.size() == 0) begin
                  flag("unexpected_frame_start");
                  cur_len = 0;
               end else cur_len = exp_frames[0].len;
               in_frame = 1; idx = 0;
            end
            if (low_run > 0) last_gap = low_run;
            low_run = 0;
            if (exp_bytes.size() == 0) flag("unexpected_rx_byte");
            else begin
               m_e = exp_bytes.pop_front();
               chk("rx_data", rx_data, m_e);
            end
            idx++;
            if (rx_good_frame || rx_bad_frame) flag("status_during_data");
         end else begin
            low_run++;
            if (prev_valid && in_frame) chk("frame_contiguous_bytes", idx, cur_len);
            if (rx_good_frame || rx_bad_frame) begin
               chk("status_right_after_last_byte", prev_valid, 1);
               if (exp_frames.size() == 0) flag("unexpected_status");
               else begin
                  m_f = exp_frames.pop_front();
                  chk("status_bad", rx_bad_frame, m_f.bad);
                  chk("status_good", rx_good_frame, !m_f.bad);
                  chk("frame_len", idx, m_f.len);
                  if (m_f.bad) mon_bad++; else mon_good++;
                  chk("good_count_at_status", good_count, mon_good);
                  chk("bad_count_at_status", bad_count, mon_bad);
               end
               in_frame = 0; idx = 0;
            end
         end
         prev_valid = rx_data_valid;
      end
   end

   initial begin
      #5000000;
      $display("FAIL watchdog_timeout @%0t", $time);
      $fatal(1, "watchdog");
   end

   // One beat starting at a negedge; returns at the negedge after its handshake.
   task automatic drive_beat(input logic [7:0] d, input logic s, input logic l, input logic u);
      bit hs;
      int w;
      s_axis_tdata = d; s_axis_tstrb = s; s_axis_tlast = l; s_axis_tuser = u;
      s_axis_tvalid = 1'b1;
      hs = 0; w = 0;
      while (!hs) begin
         hs = s_axis_tready;
         if (!hs) begin
            saw_stall = 1;
            w++;
            if (w > 50000) begin
               $display("FAIL tready_stuck_low @%0t", $time);
               $fatal(1, "tready stuck");
            end
         end
         @(posedge axi_aclk);
         @(negedge axi_aclk);
      end
   endtask

   task automatic idle_cycle();
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'($urandom_range(0, 1));
      s_axis_tdata  = 8'($urandom);
      @(negedge axi_aclk);
   endtask

   // Reference: first min(n,MAXL) strobed bytes survive; bad = tuser or truncated; n==0 is dropped.
   task automatic send_frame(input int n, input bit u, input bit rnd);
      byte unsigned d;
      bit extra, last;
      frame_t f;
      extra = rnd && (n > 0) && ($urandom_range(0, 3) == 0);
      for (int i = 0; i < n; i++) begin
         d = rnd ? 8'($urandom) : 8'(i);
         if (rnd && $urandom_range(0, 7) == 0) idle_cycle();
         if (rnd && $urandom_range(0, 7) == 0) drive_beat(8'($urandom), 1'b0, 1'b0, 1'($urandom));
         if (i < MAXL) exp_bytes.push_back(d);
         last = (i == n - 1) && !extra;
         drive_beat(d, 1'b1, last, last ? u : 1'($urandom));
      end
      if (n == 0 || extra) drive_beat(8'($urandom), 1'b0, 1'b1, u);
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      if (n == 0) st_drop++;
      else begin
         f.len = (n > MAXL) ? MAXL : n;
         f.bad = u || (n > MAXL);
         exp_frames.push_back(f);
         if (f.bad) st_bad++; else st_good++;
      end
   endtask

   task automatic wait_drain();
      int w;
      w = 0;
      while ((exp_frames.size() != 0 || exp_bytes.size() != 0) && w < 30000) begin
         @(negedge axi_aclk);
         w++;
      end
      chk("drain_frames_left", exp_frames.size(), 0);
      repeat (IFG + 4) @(negedge axi_aclk);
   endtask

   task automatic check_counts(input string tag);
      chk({tag, "_good_count"}, good_count, st_good);
      chk({tag, "_bad_count"}, bad_count, st_bad);
      chk({tag, "_drop_count"}, drop_count, st_drop);
   endtask

   initial begin
      int k, n;
      bit u;
      axi_resetn = 1'b0;
      s_axis_tdata = '0; s_axis_tstrb = 1'b0; s_axis_tuser = 1'b0;
      s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
      repeat (3) @(negedge axi_aclk);
      chk("reset_rx_data_valid", rx_data_valid, 0);
      chk("reset_rx_good", rx_good_frame, 0);
      chk("reset_rx_bad", rx_bad_frame, 0);
      chk("reset_rx_data", rx_data, 0);
      check_counts("reset");
      axi_resetn = 1'b1;
      @(negedge axi_aclk);
      chk("ready_after_reset", s_axis_tready, 1);

      // 64-byte good frame with first-byte latency of three cycles after tlast
      send_frame(64, 1'b0, 1'b0);
      k = 1;
      while (!rx_data_valid && k < 10) begin
         @(negedge axi_aclk);
         k++;
      end
      chk("first_byte_latency", k, 3);
      wait_drain();
      check_counts("t64");

      send_frame(60, 1'b1, 1'b0);
      wait_drain();
      check_counts("t60bad");

      send_frame(1600, 1'b0, 1'b0);
      wait_drain();
      check_counts("t1600trunc");

      // Back-to-back frames: inter-frame low time is IFG+2
      send_frame(60, 1'b0, 1'b0);
      send_frame(60, 1'b0, 1'b0);
      wait_drain();
      chk("ifg_low_cycles", last_gap, IFG + 2);
      check_counts("b2b");

      repeat (4) send_frame(1500, 1'b0, 1'b0);
      wait_drain();
      check_counts("four1500");

      // Many 1-byte frames outrun the read side and fill the descriptor FIFO
      saw_stall = 0;
      repeat (40) send_frame(1, 1'b0, 1'b0);
      chk("tready_backpressure", saw_stall, 1);
      wait_drain();
      check_counts("tiny");

      send_frame(1517, 1'b0, 1'b0);
      send_frame(1518, 1'b0, 1'b0);
      send_frame(1519, 1'b0, 1'b0);
      wait_drain();
      check_counts("boundary");

      send_frame(0, 1'b0, 1'b0);
      repeat (3) @(negedge axi_aclk);
      chk("drop_count_zero_len", drop_count, st_drop);

      // Reset while a 100-byte frame is being emitted
      send_frame(100, 1'b0, 1'b0);
      k = 0;
      while (!rx_data_valid && k < 20) begin
         @(negedge axi_aclk);
         k++;
      end
      chk("emitting_before_reset", rx_data_valid, 1);
      repeat (10) @(negedge axi_aclk);
      axi_resetn = 1'b0;
      #1;
      st_good = 0; st_bad = 0; st_drop = 0;
      chk("midreset_rx_data_valid", rx_data_valid, 0);
      chk("midreset_rx_data", rx_data, 0);
      chk("midreset_rx_good", rx_good_frame, 0);
      chk("midreset_rx_bad", rx_bad_frame, 0);
      check_counts("midreset");
      repeat (3) @(negedge axi_aclk);
      axi_resetn = 1'b1;
      repeat (40) @(negedge axi_aclk);
      check_counts("post_reset");

      // Randomized frames with strobe-less beats, valid gaps and length boundaries
      for (int f = 0; f < 14; f++) begin
         k = $urandom_range(0, 9);
         if (k == 0)      n = 0;
         else if (k == 1) n = 1510 + $urandom_range(0, 15);
         else             n = $urandom_range(1, 120);
         u = ($urandom_range(0, 3) == 0);
         send_frame(n, u, 1'b1);
         if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 30)) idle_cycle();
      end
      wait_drain();
      check_counts("random");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
